// File: rtl/sram_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM access controller.
// Holds the FSM encoding and the SRAM bus geometry used by the top and interface.
package sram_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_DW           = 16;
  localparam int          CNT_W             = 4;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// MEM-stage request/response signals plus the external SRAM bus.
// slave = controller side, master = pipeline and SRAM device side.
interface sram_access_ctrl_if #(
  parameter int SRAM_AW = 18
);
  import sram_access_ctrl_pkg::*;

  logic                rd_en;
  logic                wr_en;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic [31:0]         rdata;
  logic                ready;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [SRAM_DW-1:0]  sram_dq_o;
  logic [SRAM_DW-1:0]  sram_dq_i;
  logic                sram_dq_oe;
  logic                sram_we_n;
  logic                sram_oe_n;

  modport master (
    output rd_en, wr_en, addr, wdata, sram_dq_i,
    input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata, sram_dq_i,
    output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n, sram_oe_n
  );

endinterface

// File: rtl/sram_wait_counter.sv
// Hold-time counter for one halfword SRAM cycle; last flags the final cycle.
// Cleared between halves so the LO and HI phases share one instance.
module sram_wait_counter
  import sram_access_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two halfword SRAM cycles.
// ready drops while an access is in flight so the pipeline freezes on it.
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  sram_access_ctrl_if.slave  bus
);

  state_t      state;
  state_t      state_nxt;
  logic        req;
  logic        op_wr;
  logic [31:0] addr_l;
  logic [31:0] wdata_l;
  logic [31:0] rdata_r;
  logic [31:0] offset;
  logic        unused_offset_bits;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_last;

  assign req                = bus.rd_en | bus.wr_en;
  assign offset             = addr_l - ADDR_BASE;
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign bus.rdata          = rdata_r;

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)      state_nxt = LO;
      LO:      if (cnt_last) state_nxt = HI;
      HI:      if (cnt_last) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Request capture and halfword read capture; write wins when both enables are set.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_wr   <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata_r <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr   <= bus.wr_en;
        addr_l  <= bus.addr;
        wdata_l <= bus.wdata;
      end
      if (!op_wr && cnt_last && state == LO) rdata_r[15:0]  <= bus.sram_dq_i;
      if (!op_wr && cnt_last && state == HI) rdata_r[31:16] <= bus.sram_dq_i;
    end
  end

  // Strobes depend only on registered state and latched op, never on live requests.
  always_comb begin
    bus.sram_addr  = '0;
    bus.sram_dq_o  = '0;
    bus.sram_dq_oe = 1'b0;
    bus.sram_we_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.ready      = ~req | (state == DONE);
    cnt_en         = (state == LO) || (state == HI);
    cnt_clr        = (state == IDLE) || (state == DONE) || cnt_last;
    if (state == LO || state == HI) begin
      bus.sram_addr = {offset[SRAM_AW:2], (state == HI)};
      if (op_wr) begin
        bus.sram_we_n  = 1'b0;
        bus.sram_dq_oe = 1'b1;
        bus.sram_dq_o  = (state == HI) ? wdata_l[31:16] : wdata_l[15:0];
      end else begin
        bus.sram_oe_n  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: behavioural SRAM device, reference memory and
// per-cycle expected bus activity derived from address/halfword arithmetic.
module tb_sram_access_ctrl;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst;

  sram_access_ctrl_if #(.SRAM_AW(18)) bus ();

  sram_access_ctrl #(
    .ADDR_BASE   (BASE),
    .SRAM_AW     (18),
    .WAIT_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed_fn(input int i);
    return 16'((i * 40503) ^ 23130);
  endfunction

  // SRAM device model: 256 halfwords, aliased on the low address bits.
  logic [15:0] sram_mem [256];
  bit          init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= seed_fn(i);
      init_done <= 1'b1;
    end else if (!bus.sram_we_n && bus.sram_dq_oe) begin
      sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_o;
    end
  end

  assign bus.sram_dq_i = bus.sram_oe_n ? 16'h0000 : sram_mem[bus.sram_addr[7:0]];

  logic [15:0] ref_mem [256];
  logic [31:0] exp_rdata;
  int          total  = 0;
  int          passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_bus(input string tag, input logic [17:0] ea, input bit ewe_n,
                           input bit eoe_n, input bit edq_oe, input logic [15:0] edq_o,
                           input bit erdy);
    check({tag, ".addr"},  32'(bus.sram_addr),  32'(ea));
    check({tag, ".we_n"},  32'(bus.sram_we_n),  32'(ewe_n));
    check({tag, ".oe_n"},  32'(bus.sram_oe_n),  32'(eoe_n));
    check({tag, ".dq_oe"}, 32'(bus.sram_dq_oe), 32'(edq_oe));
    check({tag, ".dq_o"},  32'(bus.sram_dq_o),  32'(edq_o));
    check({tag, ".ready"}, 32'(bus.ready),      32'(erdy));
  endtask

  // One access starting from IDLE; called just after a rising edge.
  task automatic do_access(input string tag, input bit wr, input bit rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input int drop_at, input bit hold);
    logic [17:0] base;
    bit          req_on;
    bit          lo, hi;
    base   = 18'(((a - BASE) >> 2) << 1);
    req_on = 1'b1;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.addr  = a;
    bus.wdata = d;
    for (int cyc = 0; cyc <= 2 * W + 1; cyc++) begin
      @(negedge clk);
      lo = (cyc >= 1) && (cyc <= W);
      hi = (cyc > W) && (cyc <= 2 * W);
      if (lo || hi)
        check_bus(tag, hi ? (base | 18'd1) : base, !wr, wr, wr,
                  wr ? (hi ? d[31:16] : d[15:0]) : 16'h0000, !req_on);
      else
        check_bus(tag, 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000, !req_on || (cyc == 2 * W + 1));
      if (cyc == 2 * W + 1) begin
        if (wr) begin
          ref_mem[base[7:0]]         = d[15:0];
          ref_mem[base[7:0] | 8'd1]  = d[31:16];
        end else begin
          exp_rdata = {ref_mem[base[7:0] | 8'd1], ref_mem[base[7:0]]};
        end
        check({tag, ".rdata"}, bus.rdata, exp_rdata);
      end
      @(posedge clk);
      #1;
      if (cyc == drop_at) begin
        req_on    = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = $urandom;
        bus.wdata = $urandom;
      end
    end
    if (!hold) begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      @(negedge clk);
      check_bus({tag, ".idle"}, 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_fn(i);
    exp_rdata = 32'h0;

    // Reset held two cycles with a load pending.
    rst       = 1'b1;
    bus.rd_en = 1'b1;
    bus.wr_en = 1'b0;
    bus.addr  = BASE + 32'd8;
    bus.wdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      check_bus("reset", 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      check("reset.rdata", bus.rdata, 32'h0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    do_access("rst_read", 1'b0, 1'b1, BASE + 32'd8, 32'h0, -1, 1'b0);

    do_access("write", 1'b1, 1'b0, BASE + 32'd8, 32'hDEADBEEF, -1, 1'b0);
    check("write.mem_lo", 32'(sram_mem[4]), 32'h0000BEEF);
    check("write.mem_hi", 32'(sram_mem[5]), 32'h0000DEAD);

    // Back-to-back: request held straight after DONE.
    do_access("b2b_wr", 1'b1, 1'b0, BASE + 32'd8, 32'h56781234, -1, 1'b1);
    do_access("b2b_rd", 1'b0, 1'b1, BASE + 32'd8, 32'h0, -1, 1'b0);
    check("read.rdata", bus.rdata, 32'h56781234);

    // Store dropped during HI still completes.
    do_access("drop_wr", 1'b1, 1'b0, BASE + 32'd40, 32'hCAFEF00D, W + 1, 1'b0);
    do_access("drop_rd", 1'b0, 1'b1, BASE + 32'd40, 32'h0, -1, 1'b0);
    check("drop.rdata", bus.rdata, 32'hCAFEF00D);

    do_access("both", 1'b1, 1'b1, BASE + 32'd44, 32'h0BADF00D, -1, 1'b0);
    do_access("below_base", 1'b0, 1'b1, 32'd0, 32'h0, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int          kind;
      logic [31:0] a;
      int          drop;
      kind = $urandom_range(0, 2);
      a    = BASE + 32'($urandom_range(0, 127) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(0, 1023));
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * W) : -1;
      do_access("rand", kind != 1, kind != 0, a, $urandom, drop, 1'($urandom_range(0, 1)));
    end
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset during the LO phase of a load.
    bus.rd_en = 1'b1;
    bus.addr  = BASE + 32'd16;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_rdata = 32'h0;
    repeat (4) begin
      @(negedge clk);
      check_bus("midrst", 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
      check("midrst.rdata", bus.rdata, 32'h0);
      @(posedge clk);
      #1;
    end
    do_access("post_rst", 1'b0, 1'b1, BASE + 32'd16, 32'h0, -1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit SRAM.
- Takes the memory request latched in the EXE/MEM pipeline register (read/write enables, ALU result as address, Val_Rm as store data) and performs each 32-bit access as two halfword SRAM cycles.
- Returns read data to the MEM stage.
- Drives `ready` low while busy. The top level derives the pipeline `freeze = ~ready` from it, so all stage registers hold until the access completes.

Parameters:
- ADDR_BASE, 1024: CPU byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 3: cycles each halfword access is held on the bus; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  load request from EXE/MEM register (MEM_R_EN).
- wr_en  in  1  store request from EXE/MEM register (MEM_W_EN).
- addr  in  32  CPU byte address (ALU result).
- wdata  in  32  store data (Val_Rm).
- rdata  out  32  load data.
- ready  out  1  1 = no access pending or access completing this cycle.
- sram_addr  out  SRAM_AW  SRAM halfword address.
- sram_dq_o  out  16  SRAM write data.
- sram_dq_i  in  16  SRAM read data.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- Clock and reset: the only clock is clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, wait counter=0.
  - Latched op/addr/wdata = 0, rdata=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
- Reset mid-operation: the access is abandoned next edge; no completion is signalled.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en|wr_en, latch op, addr and wdata, clear the counter, then go to LO.
  - If both rd_en and wr_en are set, treat the access as a write.
- LO: drive the low halfword for WAIT_CYCLES cycles, then go to HI with the counter cleared.
- HI: drive the high halfword for WAIT_CYCLES cycles, then go to DONE.
- DONE: one cycle, then return to IDLE unconditionally.
- Back-to-back requests: a request still asserted in the cycle after DONE is a new access and is started from IDLE.
- Request inputs are ignored outside IDLE. The latched copies are used, so dropping a request mid-access does not abort it.
- ready is combinational: `ready = ~(rd_en|wr_en) | (state==DONE)`.
  - In IDLE with a request pending, ready=0.
  - Latency: ready is low for exactly 1+2*WAIT_CYCLES cycles per access and high in DONE.
- Address calculation:
  - `word = (addr_l - ADDR_BASE) >> 2` (32-bit unsigned subtract, wrap-around allowed).
  - `sram_addr = {word[SRAM_AW-2:0], half}`, where half=0 in LO and 1 in HI.
  - In IDLE/DONE, sram_addr=0.
- Write:
  - In LO/HI: sram_we_n=0 and sram_dq_oe=1.
  - sram_dq_o = wdata_l[15:0] in LO and wdata_l[31:16] in HI.
  - sram_oe_n=1 throughout.
- Read:
  - In LO/HI: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - On the last LO cycle, sram_dq_i is registered into rdata[15:0].
  - On the last HI cycle, sram_dq_i is registered into rdata[31:16].
  - rdata holds its value until overwritten by a later read; writes never change it.
- sram_dq_o is 0 whenever sram_dq_oe=0.
- Strobe outputs are decoded combinationally from registered state and latched op only, so they are glitch-free with respect to the request inputs.

Decomposition:
- Shared package: FSM state encoding (2-bit enum IDLE/LO/HI/DONE), ADDR_BASE default, SRAM data width constant (16).
- One natural sub-module: sram_wait_counter.
  - A 4-bit counter with clear/enable and a `last` output, asserted when count == WAIT_CYCLES-1.
  - Used identically in LO and HI.

Test Plan:
- Reset: hold rst 2 cycles with rd_en=1 → all SRAM strobes inactive, rdata=0, state IDLE. After rst falls, ready=0 for 7 cycles (WAIT_CYCLES=3), then high for 1.
- Write: addr=1024+8, wdata=0xDEADBEEF.
  - sram_addr=4 with dq_o=0xBEEF and we_n=0 for 3 cycles.
  - Then sram_addr=5 with dq_o=0xDEAD for 3 cycles.
  - ready=1 on cycle 8.
- Read: SRAM model returns 0x1234 at addr 4 and 0x5678 at addr 5; issue rd_en with addr=1032 → rdata=0x56781234 when ready rises; oe_n=0 and dq_oe=0 throughout.
- Back-to-back: write followed immediately by a read (request held after DONE) → second access starts the cycle after DONE, with no lost or duplicated cycle.
- Mid-op: drop wr_en during HI → access still completes, second halfword is written, ready=1 in DONE.
- Mid-op reset: assert rst in LO of a read → next cycle IDLE, we_n=oe_n=1, rdata=0, with no partial update afterwards.
